// File: rtl/qpsk_interleaver.sv
// qpsk_interleaver
//   Block interleaver for the QPSK path (s = 1, so only the first
//   permutation applies). Input bit k of each NCBPS-bit block is written to
//   position m = (NCBPS/D)*(k mod D) + floor(k/D) of a ping-pong bank. The
//   other bank is read out sequentially in order j = 0..NCBPS-1.
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   valid_in   upstream coded bit valid
//   data_in    coded bit, in order k = 0..NCBPS-1
//   ready_in   block can accept data_in this cycle (registered state only)
//   valid_out  interleaved bit valid toward the modulator
//   data_out   interleaved bit, in order j = 0..NCBPS-1
//   ready_out  downstream accepts data_out
module qpsk_interleaver #(
  parameter int NCBPS = 192,
  parameter int D     = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic valid_in,
  input  logic data_in,
  output logic ready_in,
  output logic valid_out,
  output logic data_out,
  input  logic ready_out
);

  localparam int ROWS = NCBPS / D;
  localparam int AW   = $clog2(NCBPS);
  localparam int RW   = $clog2(D);
  localparam int CW   = $clog2(ROWS);

  localparam logic [AW-1:0] LAST_IDX = AW'(NCBPS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(D - 1);
  localparam logic [AW-1:0] M_STEP   = AW'(ROWS);

  // Handshake / bank state
  logic [1:0]    full;
  logic [1:0]    full_nxt;
  logic          wr_bank;
  logic          rd_bank;

  // Write-side counters: k is the input index, row = k mod D,
  // col = floor(k/D), m is the interleaved write address.
  logic [AW-1:0] k;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [AW-1:0] m;

  // Read-side counter
  logic [AW-1:0] j;

  logic [NCBPS-1:0] bank [2];

  logic accept;
  logic xfer;
  logic last_in;
  logic last_out;

  always_comb begin
    ready_in  = !full[wr_bank];
    valid_out = full[rd_bank];
    data_out  = full[rd_bank] & bank[rd_bank][j];
    accept    = valid_in && ready_in;
    xfer      = valid_out && ready_out;
    last_in   = (k == LAST_IDX);
    last_out  = (j == LAST_IDX);
  end

  // A filled bank and a drained bank are always distinct when both events
  // land on the same edge (accept needs !full[wr_bank], xfer needs
  // full[rd_bank]), so set and clear never collide on one bit.
  always_comb begin
    full_nxt = full;
    if (accept && last_in) begin
      full_nxt[wr_bank] = 1'b1;
    end
    if (xfer && last_out) begin
      full_nxt[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full <= '0;
    end else begin
      full <= full_nxt;
    end
  end

  // m tracks 12*row + col incrementally: +ROWS per bit within a column
  // sweep, restarting at col+1 when row wraps, so no multiplier is needed.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_bank <= 1'b0;
      k       <= '0;
      row     <= '0;
      col     <= '0;
      m       <= '0;
    end else if (accept) begin
      if (last_in) begin
        wr_bank <= ~wr_bank;
        k       <= '0;
        row     <= '0;
        col     <= '0;
        m       <= '0;
      end else begin
        k <= k + AW'(1);
        if (row == ROW_LAST) begin
          row <= '0;
          col <= col + CW'(1);
          m   <= AW'(col) + AW'(1);
        end else begin
          row <= row + RW'(1);
          m   <= m + M_STEP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_bank <= 1'b0;
      j       <= '0;
    end else if (xfer) begin
      if (last_out) begin
        rd_bank <= ~rd_bank;
        j       <= '0;
      end else begin
        j <= j + AW'(1);
      end
    end
  end

  // Bank storage is not reset; the full flags alone decide what is visible.
  always_ff @(posedge clk) begin
    if (accept) begin
      bank[wr_bank][m] <= data_in;
    end
  end

endmodule

// File: doc/qpsk_interleaver.md
QPSK_INTERLEAVER -- requirements
Module: qpsk_interleaver

Interface
REQ-001 SHALL use reset rstn, asynchronous, active-low; clock clk.
REQ-002 SHALL have parameter NCBPS, default 192, meaning coded bits per interleaver block (QPSK, 96 symbols).
REQ-003 SHALL have parameter D, default 16, meaning first-permutation column count; NCBPS/D = 12 rows.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rstn  input  1  async active-low reset.
REQ-006 SHALL have port valid_in  input  1  upstream (randomizer/FEC) bit valid.
REQ-007 SHALL have port data_in  input  1  coded bit, in order k = 0..191.
REQ-008 SHALL have port ready_in  output  1  block can accept data_in this cycle.
REQ-009 SHALL have port valid_out  output  1  interleaved bit valid, toward the QPSK modulator.
REQ-010 SHALL have port data_out  output  1  interleaved bit, in order j = 0..191.
REQ-011 SHALL have port ready_out  input  1  downstream modulator accepts data_out.

Function
REQ-012 SHALL accept an input bit on each rising edge where valid_in && ready_in, and otherwise SHALL ignore data_in.
REQ-013 SHALL transfer an output bit on each rising edge where valid_out && ready_out.
REQ-014 SHALL map input index k to output index m = 12*(k mod 16) + floor(k/16), per 802.16 first permutation; the QPSK second permutation (s=1) is identity.
REQ-015 SHALL compute m from a row counter (k mod 16, 0..15) and column counter (floor(k/16), 0..11), with no divider or multiplier wider than 8 bits.
REQ-016 SHALL store bits in two 192-bit banks (ping-pong), write at address m of wr_bank, and read sequentially at address j of rd_bank.
REQ-017 SHALL keep a registered full flag per bank; the flag is set on the edge accepting k=191 and cleared on the edge transferring j=191.
REQ-018 SHALL toggle wr_bank and reset k to 0 on the edge accepting k=191; SHALL toggle rd_bank and reset j to 0 on the edge transferring j=191.
REQ-019 SHALL drive ready_in = !full[wr_bank] from registered state only.
REQ-020 SHALL drive valid_out = full[rd_bank] and data_out = bank[rd_bank][j] from registers, with no combinational path from ready_out or valid_in.
REQ-021 SHALL have write-side latency such that valid_out is high in the cycle immediately after the edge accepting k=191 when rd_bank was empty.
REQ-022 SHALL hold data_out and valid_out stable while valid_out && !ready_out.
REQ-023 SHALL sustain one bit per cycle in and out continuously across block boundaries, with zero bubbles when both sides are always ready.
REQ-024 SHALL correctly set one flag and clear the other when the edge accepting k=191 coincides with the edge transferring j=191.
REQ-025 SHALL keep ready_in low, and k unchanged, when both banks are full.
REQ-026 SHALL keep k and its counters unchanged when valid_in is low mid-block; a partial block SHALL never be emitted.

Reset
REQ-027 SHALL, on rstn low, asynchronously clear: full flags to 00, wr_bank and rd_bank to 0, k/row/col/j to 0, valid_out to 0, data_out to 0; ready_in SHALL be 1 after reset.
REQ-028 SHALL discard a partially written block and any undrained block on reset mid-operation; bank contents need not be cleared.

Verification
REQ-029 SHALL cover: 192 bits with only k=1 set, ready_out=1 -> single 1 at output j=12, valid_out high the cycle after k=191 is accepted.
REQ-030 SHALL cover: only k=16 set -> 1 at j=1; only k=191 set -> 1 at j=191; only k=0 set -> 1 at j=0.
REQ-031 SHALL cover: ready_out low for 3 cycles at j=50 -> data_out/valid_out frozen, j resumes at 50, no bit lost or duplicated.
REQ-032 SHALL cover: ready_out=0 while 384 bits are offered -> ready_in falls after the 384th accepted bit, and the 385th bit is held until the first output transfer frees a bank.
REQ-033 SHALL cover: 4 random blocks back-to-back, both sides always ready -> 768 consecutive valid_out cycles matching the reference permutation model.
REQ-034 SHALL cover: rstn pulsed at k=100 -> valid_out 0 and ready_in 1 after reset, and the next full block is interleaved correctly.
